// File: rtl/core_sim_ctrl.sv
// Run controller for core-level benches: sequences core reset, latches PC-init mode, arbitrates IRQs, times out the run.
// Optional WFI auto-wake enabled by defining CORE_SIM_CTRL_WFI_WAKE_EN.
module core_sim_ctrl #(
  parameter int RST_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int IRQ_CH         = 2,
  parameter int CNT_W          = 16,
  parameter int WAKE_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_init_sel,
  input  logic [IRQ_CH-1:0] irq_trig,
  input  logic [IRQ_CH-1:0] irq_ack,
  input  logic              core_wfi,
  input  logic              core_unexcp_err,
  output logic              core_rst_n,
  output logic              pc_init_use,
  output logic [IRQ_CH-1:0] irq_pend,
  output logic              ext_irq,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done,
  output logic              pass,
  output logic              fail
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_END   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                pc_init_use_q, pc_init_use_d;
  logic [IRQ_CH-1:0]   irq_pend_q, irq_pend_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                wfi_wake;

`ifdef CORE_SIM_CTRL_WFI_WAKE_EN
  localparam logic [CNT_W-1:0] WAKE_CNT = CNT_W'(WAKE_CYCLES);

  logic [CNT_W-1:0] wfi_cnt_q, wfi_cnt_d;

  // The wake cycle itself restarts the count; pending IRQs hold it at zero.
  always_comb begin
    wfi_wake  = (state_q == S_RUN) && (wfi_cnt_q == WAKE_CNT);
    wfi_cnt_d = '0;
    if ((state_q == S_RUN) && !wfi_wake && core_wfi && (irq_pend_q == '0)) begin
      wfi_cnt_d = wfi_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wfi_cnt_q <= '0;
    end else begin
      wfi_cnt_q <= wfi_cnt_d;
    end
  end
`else
  localparam int wake_cycles_unused = WAKE_CYCLES;
  logic core_wfi_unused;
  assign core_wfi_unused = core_wfi;
  assign wfi_wake        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cycle_cnt_d   = cycle_cnt_q;
    core_rst_n_d  = core_rst_n_q;
    pc_init_use_d = pc_init_use_q;
    irq_pend_d    = '0;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;

    case (state_q)
      S_IDLE: begin
        cycle_cnt_d  = '0;
        done_d       = 1'b0;
        pass_d       = 1'b0;
        fail_d       = 1'b0;
        core_rst_n_d = 1'b0;
        if (start) begin
          state_d       = S_RESET;
          pc_init_use_d = pc_init_sel;
        end
      end
      S_RESET: begin
        core_rst_n_d = 1'b0;
        if (cycle_cnt_q == RST_LAST) begin
          state_d      = S_RUN;
          cycle_cnt_d  = '0;
          core_rst_n_d = 1'b1;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Set wins over ack on the same channel.
        irq_pend_d = (irq_pend_q & ~irq_ack) | irq_trig | IRQ_CH'(wfi_wake);
        if (core_unexcp_err) begin
          state_d    = S_END;
          done_d     = 1'b1;
          fail_d     = 1'b1;
          irq_pend_d = '0;
        end else if (cycle_cnt_q == TO_LAST) begin
          state_d    = S_END;
          done_d     = 1'b1;
          pass_d     = 1'b1;
          irq_pend_d = '0;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end
      S_END: begin
        if (start) begin
          state_d       = S_RESET;
          cycle_cnt_d   = '0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          core_rst_n_d  = 1'b0;
          pc_init_use_d = pc_init_sel;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cycle_cnt_q   <= '0;
      core_rst_n_q  <= 1'b0;
      pc_init_use_q <= 1'b0;
      irq_pend_q    <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_cnt_q   <= cycle_cnt_d;
      core_rst_n_q  <= core_rst_n_d;
      pc_init_use_q <= pc_init_use_d;
      irq_pend_q    <= irq_pend_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign pc_init_use = pc_init_use_q;
  assign irq_pend    = irq_pend_q;
  assign ext_irq     = |irq_pend_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_core_sim_ctrl.sv
// Bench for core_sim_ctrl: per-run timeline model feeds an expected queue, a monitor compares each post-edge snapshot.
module tb_core_sim_ctrl;
  localparam int RST_CYCLES     = 8;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int IRQ_CH         = 2;
  localparam int CNT_W          = 16;
  localparam int WAKE_CYCLES    = 4;
  localparam int SW             = CNT_W + IRQ_CH + 6;
  localparam int L              = RST_CYCLES + TIMEOUT_CYCLES + 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic              pc_init_sel;
  logic [IRQ_CH-1:0] irq_trig;
  logic [IRQ_CH-1:0] irq_ack;
  logic              core_wfi;
  logic              core_unexcp_err;
  logic              core_rst_n;
  logic              pc_init_use;
  logic [IRQ_CH-1:0] irq_pend;
  logic              ext_irq;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              done;
  logic              pass;
  logic              fail;

  core_sim_ctrl #(
    .RST_CYCLES    (RST_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .IRQ_CH        (IRQ_CH),
    .CNT_W         (CNT_W),
    .WAKE_CYCLES   (WAKE_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pc_init_sel    (pc_init_sel),
    .irq_trig       (irq_trig),
    .irq_ack        (irq_ack),
    .core_wfi       (core_wfi),
    .core_unexcp_err(core_unexcp_err),
    .core_rst_n     (core_rst_n),
    .pc_init_use    (pc_init_use),
    .irq_pend       (irq_pend),
    .ext_irq        (ext_irq),
    .cycle_cnt      (cycle_cnt),
    .done           (done),
    .pass           (pass),
    .fail           (fail)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0] exp_q[$];
  int            tag_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  logic              st_a   [L];
  logic              err_a  [L];
  logic              wfi_a  [L];
  logic [IRQ_CH-1:0] trig_a [L];
  logic [IRQ_CH-1:0] ack_a  [L];
  logic [SW-1:0]     exp_a  [L];

  function automatic logic [SW-1:0] dut_snap();
    return {core_rst_n, pc_init_use, irq_pend, ext_irq, done, pass, fail, cycle_cnt};
  endfunction

  task automatic check(input string name, input int tag, input logic [SW-1:0] got,
                       input logic [SW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s tag %0d: actual %h required %h (rst_n,pc,pend,ext,done,pass,fail,cnt)",
                  name, tag, got, exp);
  endtask

  task automatic check_reset(input string name);
    check(name, 0, dut_snap(), '0);
  endtask

  // Phase after edge k of a run that ends on run cycle e: 0 reset, 1 run, 2 end.
  function automatic int phase(input int k, input int e);
    if (k < RST_CYCLES) return 0;
    if (k <= RST_CYCLES + e) return 1;
    return 2;
  endfunction

  // Edge 0 samples start; modes: 0 quiet, 1 directed irq, 2 random, 3 wfi hold, 4 ch0 irq.
  task automatic do_run(input int run_id, input logic pc_sel, input int err_r,
                        input int mode, input int abort_k);
    bit                hit;
    int                e, last, streak, cnt;
    bit                wake, run_before;
    logic [IRQ_CH-1:0] pend;
    hit = (err_r >= 0) && (err_r < TIMEOUT_CYCLES);
    e   = hit ? err_r : TIMEOUT_CYCLES - 1;
    for (int k = 0; k < L; k++) begin
      st_a[k] = (k == 0); err_a[k] = 1'b0; wfi_a[k] = 1'b0;
      trig_a[k] = '0; ack_a[k] = '0;
      if (mode == 2) begin
        if ($urandom_range(0, 3) == 0) trig_a[k] = IRQ_CH'($urandom_range(0, (1 << IRQ_CH) - 1));
        if ($urandom_range(0, 2) == 0) ack_a[k] = IRQ_CH'($urandom_range(0, (1 << IRQ_CH) - 1));
        wfi_a[k] = ($urandom_range(0, 3) != 0);
        if (k >= 1 && k <= RST_CYCLES + e + 1) st_a[k] = ($urandom_range(0, 7) == 0);
        if ((k >= 1 && k <= RST_CYCLES) || k >= RST_CYCLES + e + 2)
          err_a[k] = ($urandom_range(0, 5) == 0);
      end
      if (mode == 1) begin
        if (k == RST_CYCLES + 4) trig_a[k][IRQ_CH-1] = 1'b1;
        if (k == RST_CYCLES + 7) begin trig_a[k][IRQ_CH-1] = 1'b1; ack_a[k][IRQ_CH-1] = 1'b1; end
        if (k == RST_CYCLES + 8) ack_a[k][IRQ_CH-1] = 1'b1;
      end
      if (mode == 3 && k >= RST_CYCLES + 3) wfi_a[k] = 1'b1;
      if (mode == 4 && k == RST_CYCLES + 2) trig_a[k][0] = 1'b1;
      if (hit && k == RST_CYCLES + err_r + 1) err_a[k] = 1'b1;
    end
    // reference timeline
    pend = '0; streak = 0;
    for (int k = 0; k < L; k++) begin
      run_before = (k >= 1) && (phase(k - 1, e) == 1);
      wake = 1'b0;
      if (run_before) begin
`ifdef CORE_SIM_CTRL_WFI_WAKE_EN
        wake = (streak == WAKE_CYCLES);
        if (wake) streak = 0;
        else if (wfi_a[k] && pend == '0) streak++;
        else streak = 0;
`endif
      end else begin
        streak = 0;
      end
      if (run_before && phase(k, e) == 1) pend = (pend & ~ack_a[k]) | trig_a[k] | IRQ_CH'(wake);
      else pend = '0;
      case (phase(k, e))
        0:       cnt = k;
        1:       cnt = k - RST_CYCLES;
        default: cnt = e;
      endcase
      exp_a[k] = {k >= RST_CYCLES, pc_sel, pend, |pend, phase(k, e) == 2,
                  phase(k, e) == 2 && !hit, phase(k, e) == 2 && hit, CNT_W'(cnt)};
    end
    // driver
    last = (abort_k >= 0) ? abort_k : L - 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      start = st_a[k]; pc_init_sel = (k == 0) ? pc_sel : 1'(($urandom_range(0, 1)));
      core_unexcp_err = err_a[k]; core_wfi = wfi_a[k];
      irq_trig = trig_a[k]; irq_ack = ack_a[k];
      exp_q.push_back(exp_a[k]);
      tag_q.push_back(run_id * 100 + k);
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("snapshot", tag_q.pop_front(), dut_snap(), exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pc_init_sel = 1'b0; irq_trig = '0; irq_ack = '0;
    core_wfi = 1'b0; core_unexcp_err = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset("reset_state");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #2 check_reset("idle_hold");

    do_run(1, 1'b1, -1, 0, -1);              // timeout -> pass
    do_run(2, 1'b0, 5, 0, -1);               // error mid-run
    do_run(3, 1'b1, TIMEOUT_CYCLES - 1, 0, -1); // error on timeout cycle
    do_run(4, 1'b0, -1, 1, -1);              // directed irq set/ack
    do_run(5, 1'b1, -1, 3, -1);              // wfi held
    for (int r = 0; r < 8; r++) begin
      do_run(10 + r, 1'(($urandom_range(0, 1))),
             ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, TIMEOUT_CYCLES - 1)), 2, -1);
    end

    do_run(30, 1'b1, -1, 4, RST_CYCLES + 4); // stop during run cycle 4
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("async_reset");
    @(negedge clk);
    rst = 1'b0; start = 1'b0; irq_trig = '0; irq_ack = '0; core_unexcp_err = 1'b0; core_wfi = 1'b0;
    @(posedge clk);
    #2 check_reset("post_reset_idle");
    do_run(31, 1'b0, -1, 0, -1);             // full replay after reset
    do_run(32, 1'b1, -1, 2, -1);

    @(negedge clk);
    start = 1'b0; irq_trig = '0; irq_ack = '0; core_unexcp_err = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: actual %0d entries left required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
